// File: rtl/regfile_pkg.sv
// Shared definitions for the register bank: default geometry, address-width
// helper and port-slice index helper used by the bank, its interface and its
// read ports.
package regfile_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_DEPTH  = 32;
  localparam int unsigned DEF_NREAD  = 2;
  localparam int unsigned DEF_NWRITE = 1;

  // Address bits needed for a given depth (minimum 1 bit).
  function automatic int unsigned addr_bits(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Low bit of port <port> inside a flattened bus of <w>-bit slices.
  function automatic int unsigned slice_lo(input int unsigned port, input int unsigned w);
    return port * w;
  endfunction

endpackage

// File: rtl/regfile_bank_if.sv
// Port bundle between decode/writeback (master) and the register bank (slave).
//   we/waddr/wdata : NWRITE write ports, flattened, port k in slice k
//   re/raddr       : NREAD read requests, flattened, port j in slice j
//   rdata/rvalid   : registered read results, port j in slice j
interface regfile_bank_if
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned NREAD  = DEF_NREAD,
  parameter int unsigned NWRITE = DEF_NWRITE
);
  localparam int unsigned AW = addr_bits(DEPTH);

  logic [NWRITE-1:0]       we;
  logic [NWRITE*AW-1:0]    waddr;
  logic [NWRITE*WIDTH-1:0] wdata;
  logic [NREAD-1:0]        re;
  logic [NREAD*AW-1:0]     raddr;
  logic [NREAD*WIDTH-1:0]  rdata;
  logic [NREAD-1:0]        rvalid;

  modport master (output we, waddr, wdata, re, raddr, input rdata, rvalid);
  modport slave  (input we, waddr, wdata, re, raddr, output rdata, rvalid);

endinterface

// File: rtl/regfile_rdport.sv
// One registered read port of the register bank.
//   clk, clr        : clock, synchronous active-high clear
//   re, raddr       : read request for this port
//   mem             : current storage contents
//   we/waddr/wdata  : this cycle's write ports, used for bypass
//   rdata, rvalid   : registered result; rdata holds while re is low
module regfile_rdport #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NWRITE   = 1,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    re,
  input  logic [AW-1:0]           raddr,
  input  logic [WIDTH-1:0]        mem [DEPTH],
  input  logic [NWRITE-1:0]       we,
  input  logic [NWRITE*AW-1:0]    waddr,
  input  logic [NWRITE*WIDTH-1:0] wdata,
  output logic [WIDTH-1:0]        rdata,
  output logic                    rvalid
);
  logic [WIDTH-1:0] rdata_q, rdata_d, sel;
  logic             rvalid_q, rvalid_d;

  always_comb begin
    sel = mem[raddr];
    // Ascending scan lets the highest-numbered matching write port win,
    // which matches the storage collision rule.
    if (BYPASS != 0) begin
      for (int unsigned k = 0; k < NWRITE; k++) begin
        if (we[k] && (waddr[k*AW +: AW] == raddr)) sel = wdata[k*WIDTH +: WIDTH];
      end
    end
    if ((ZERO_REG != 0) && (raddr == '0)) sel = '0;
    rdata_d  = re ? sel : rdata_q;
    rvalid_d = re;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

endmodule

// File: rtl/regfile_bank.sv
// Multi-ported register bank: DEPTH x WIDTH flop storage, NWRITE write ports
// (highest port wins on address collision), NREAD registered read ports with
// optional write-to-read bypass and optional hardwired-zero entry 0.
//   clk : clock
//   clr : synchronous active-high clear of storage and read ports
//   bus : regfile_bank_if slave modport carrying all read/write ports
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned NREAD    = DEF_NREAD,
  parameter int unsigned NWRITE   = DEF_NWRITE,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input logic           clk,
  input logic           clr,
  regfile_bank_if.slave bus
);
  localparam int unsigned AW = addr_bits(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wa;
  logic [WIDTH-1:0] rd_data [NREAD];
  logic [NREAD-1:0] rd_valid;

  always_comb begin
    mem_d = mem_q;
    wa    = '0;
    // Later ports overwrite earlier ones, so port NWRITE-1 wins a collision.
    for (int unsigned k = 0; k < NWRITE; k++) begin
      wa = bus.waddr[slice_lo(k, AW) +: AW];
      if (bus.we[k] && !((ZERO_REG != 0) && (wa == '0))) begin
        mem_d[wa] = bus.wdata[slice_lo(k, WIDTH) +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) mem_q <= '{default: '0};
    else     mem_q <= mem_d;
  end

  for (genvar j = 0; j < NREAD; j++) begin : g_rd
    regfile_rdport #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .AW       (AW),
      .NWRITE   (NWRITE),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rdport (
      .clk    (clk),
      .clr    (clr),
      .re     (bus.re[j]),
      .raddr  (bus.raddr[j*AW +: AW]),
      .mem    (mem_q),
      .we     (bus.we),
      .waddr  (bus.waddr),
      .wdata  (bus.wdata),
      .rdata  (rd_data[j]),
      .rvalid (rd_valid[j])
    );
  end

  always_comb begin
    bus.rdata = '0;
    for (int unsigned j = 0; j < NREAD; j++) begin
      bus.rdata[slice_lo(j, WIDTH) +: WIDTH] = rd_data[j];
    end
  end

  assign bus.rvalid = rd_valid;

endmodule
